// File: rtl/midi_voice_alloc.sv
// MIDI byte-stream parser with running status and channel filtering, feeding a
// voice-slot table that is presented as {note, velocity} words plus an on-mask.
module midi_voice_alloc #(
    parameter int NUM_VOICES   = 5,
    parameter int FIRST_SLOT   = 1,
    parameter int OMNI         = 1,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic [15:0]           midi_burst_data_out [NUM_VOICES],
    output logic [NUM_VOICES-1:0] on_array_out,
    output logic                  midi_burst_change_out,
    output logic                  voice_overflow_out
);

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_status_hi;
    logic                  r_status_valid;
    logic [6:0]            r_d1;

    logic                  w_realtime;
    logic                  w_is_status;
    logic                  w_is_data;
    logic                  w_chan_ok;
    logic                  w_voice_status;
    logic                  w_d1_accept;
    logic                  w_d2_accept;
    logic                  w_note_on;
    logic                  w_note_off;
    logic                  w_all_off;

    logic [15:0]           r_data [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_on;
    logic                  r_change;
    logic                  r_overflow;
    logic [15:0]           w_next_data [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_next_on;
    logic [NUM_VOICES-1:0] w_hit_vec;
    logic [NUM_VOICES-1:0] w_free_vec;
    logic [NUM_VOICES-1:0] w_free_first;
    logic                  w_change;
    logic                  w_overflow;

    // Real-time bytes are invisible to the parser: neither status nor data.
    assign w_realtime     = (byte_in >= 8'hF8);
    assign w_is_status    = byte_valid_in && byte_in[7] && !w_realtime;
    assign w_is_data      = byte_valid_in && !byte_in[7];
    assign w_chan_ok      = (OMNI != 0) || (byte_in[3:0] == MIDI_CHANNEL[3:0]);
    assign w_voice_status = ((byte_in[7:5] == 3'b100) || (byte_in[7:4] == 4'hB)) && w_chan_ok;
    assign w_d1_accept    = w_is_data &&
                            ((r_state == WAIT_D1) || ((r_state == WAIT_STATUS) && r_status_valid));
    assign w_d2_accept    = w_is_data && (r_state == WAIT_D2);

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= WAIT_STATUS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_is_status) begin
            w_next_state = w_voice_status ? WAIT_D1 : WAIT_STATUS;
        end else if (w_d1_accept) begin
            w_next_state = WAIT_D2;
        end else if (w_d2_accept) begin
            w_next_state = WAIT_STATUS;
        end
    end

    always_comb begin
        w_note_on  = 1'b0;
        w_note_off = 1'b0;
        w_all_off  = 1'b0;
        if (w_d2_accept) begin
            case (r_status_hi)
                4'h9: begin
                    w_note_on  = (byte_in != 8'h00);
                    w_note_off = (byte_in == 8'h00);
                end
                4'h8:    w_note_off = 1'b1;
                4'hB:    w_all_off  = (r_d1 == 7'h7B);
                default: ;
            endcase
        end
    end

    // Running status survives message completion; any non-voice status clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_status_hi    <= 4'h0;
            r_status_valid <= 1'b0;
            r_d1           <= 7'h00;
        end else begin
            if (w_is_status) begin
                r_status_hi    <= byte_in[7:4];
                r_status_valid <= w_voice_status;
            end
            if (w_d1_accept) begin
                r_d1 <= byte_in[6:0];
            end
        end
    end

    // Reserved slots never match and are never free, so they are never written.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_hit_vec[i]  = (i >= FIRST_SLOT) && r_on[i] && (r_data[i][14:8] == r_d1);
            w_free_vec[i] = (i >= FIRST_SLOT) && !r_on[i];
        end
    end

    // Isolate the lowest set bit: lowest-index free slot wins.
    assign w_free_first = w_free_vec & (~w_free_vec + NUM_VOICES'(1));

    always_comb begin
        w_next_data = r_data;
        w_next_on   = r_on;
        w_change    = 1'b0;
        w_overflow  = 1'b0;
        if (w_note_on) begin
            if (|w_hit_vec) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (w_hit_vec[i]) begin
                        w_next_data[i][7:0] = byte_in;
                    end
                end
                w_change = 1'b1;
            end else if (|w_free_vec) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (w_free_first[i]) begin
                        w_next_data[i] = {1'b0, r_d1, byte_in};
                        w_next_on[i]   = 1'b1;
                    end
                end
                w_change = 1'b1;
            end else begin
                w_overflow = 1'b1;
            end
        end else if (w_note_off) begin
            if (|w_hit_vec) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (w_hit_vec[i]) begin
                        w_next_data[i] = 16'h0000;
                        w_next_on[i]   = 1'b0;
                    end
                end
                w_change = 1'b1;
            end
        end else if (w_all_off && (|r_on)) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                w_next_data[i] = 16'h0000;
            end
            w_next_on = '0;
            w_change  = 1'b1;
        end
    end

    // NOTE: the slot table is reset because it drives outputs that must read 0 after reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_data[i] <= 16'h0000;
            end
            r_on       <= '0;
            r_change   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_data     <= w_next_data;
            r_on       <= w_next_on;
            r_change   <= w_change;
            r_overflow <= w_overflow;
        end
    end

    assign midi_burst_data_out   = r_data;
    assign on_array_out          = r_on;
    assign midi_burst_change_out = r_change;
    assign voice_overflow_out    = r_overflow;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: an omni instance is checked on every
// cycle against queued expectations; a channel-0 instance checks filtering.
module tb_midi_voice_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_d;
    logic        valid;

    logic [15:0] o_data [5];
    logic [4:0]  o_on;
    logic        o_chg;
    logic        o_ovf;
    logic [15:0] c_data [5];
    logic [4:0]  c_on;
    logic        c_chg;
    logic        c_ovf;

    typedef struct packed {
        logic        chg;
        logic        ovf;
        logic [4:0]  mask;
        logic [79:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [4:0]  cur_mask;
    logic [79:0] cur_data;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          chan_pulses = 0;
    string       tname;

    always #5 clk = ~clk;

    midi_voice_alloc u_omni (
        .clk_in                (clk),
        .rst_in                (rst),
        .byte_in               (byte_d),
        .byte_valid_in         (valid),
        .midi_burst_data_out   (o_data),
        .on_array_out          (o_on),
        .midi_burst_change_out (o_chg),
        .voice_overflow_out    (o_ovf)
    );

    midi_voice_alloc #(.OMNI(0), .MIDI_CHANNEL(0)) u_chan (
        .clk_in                (clk),
        .rst_in                (rst),
        .byte_in               (byte_d),
        .byte_valid_in         (valid),
        .midi_burst_data_out   (c_data),
        .on_array_out          (c_on),
        .midi_burst_change_out (c_chg),
        .voice_overflow_out    (c_ovf)
    );

    function automatic logic [79:0] tbl(input logic [15:0] s0, s1, s2, s3, s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    function automatic logic [79:0] obs();
        logic [79:0] p;
        for (int i = 0; i < 5; i++) p[16*i +: 16] = o_data[i];
        return p;
    endfunction

    task automatic push(input logic chg, input logic ovf, input logic [4:0] m, input logic [79:0] d);
        exp_t e;
        e.chg  = chg;
        e.ovf  = ovf;
        e.mask = m;
        e.data = d;
        sb.push_back(e);
    endtask

    // Called once per cycle at the falling edge: strobes pop the scoreboard,
    // quiet cycles must show the table unchanged since the last strobe.
    task automatic sample();
        exp_t        e;
        logic [79:0] d;
        d = obs();
        if (c_chg) chan_pulses++;
        n_checks++;
        if (o_chg || o_ovf) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected_strobe: chg=%0b ovf=%0b mask=%b, required no strobe",
                         tname, o_chg, o_ovf, o_on);
            end else begin
                e = sb.pop_front();
                if ({o_chg, o_ovf, o_on, d} !== e) begin
                    n_fail++;
                    $display("FAIL %s strobe_result: got chg=%0b ovf=%0b mask=%b data=%h, required chg=%0b ovf=%0b mask=%b data=%h",
                             tname, o_chg, o_ovf, o_on, d, e.chg, e.ovf, e.mask, e.data);
                end
                cur_mask = e.mask;
                cur_data = e.data;
            end
        end else if ({o_on, d} !== {cur_mask, cur_data}) begin
            n_fail++;
            $display("FAIL %s table_stable: got mask=%b data=%h, required mask=%b data=%h",
                     tname, o_on, d, cur_mask, cur_data);
        end
    endtask

    task automatic tick(input logic [7:0] b, input logic v);
        @(negedge clk);
        sample();
        byte_d = b;
        valid  = v;
    endtask

    task automatic send(input logic [7:0] b);
        tick(b, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(8'h00, 1'b0);
    endtask

    task automatic end_check();
        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_strobe: %0d expected strobes not seen, required 0", tname, sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        cur_mask = '0;
        cur_data = '0;
    endtask

    task automatic test_reset();
        tname = "reset";
        rst    = 1'b1;
        valid  = 1'b0;
        byte_d = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_chg, o_ovf, o_on, obs()} !== 87'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got chg=%0b ovf=%0b mask=%b data=%h, required all 0",
                     o_chg, o_ovf, o_on, obs());
        end
        n_checks++;
        if ({c_chg, c_ovf, c_on} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_chan_outputs: got chg=%0b ovf=%0b mask=%b, required all 0", c_chg, c_ovf, c_on);
        end
        rst      = 1'b0;
        cur_mask = '0;
        cur_data = '0;
        idle(3);
    endtask

    task automatic test_note_on();
        tname = "note_on";
        do_reset();
        send(8'h90); send(8'h3C);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C64, 16'h0, 16'h0, 16'h0));
        send(8'h64);
        end_check();
    endtask

    task automatic test_back_to_back();
        tname = "running_status";
        do_reset();
        send(8'h90); send(8'h40);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h4050, 16'h0, 16'h0, 16'h0));
        send(8'h50);
        send(8'h43);
        push(1'b1, 1'b0, 5'b00110, tbl(16'h0, 16'h4050, 16'h4360, 16'h0, 16'h0));
        send(8'h60);
        send(8'h40);
        push(1'b1, 1'b0, 5'b00100, tbl(16'h0, 16'h0, 16'h4360, 16'h0, 16'h0));
        send(8'h00);
        end_check();
    endtask

    task automatic test_overflow();
        logic [79:0] full;
        tname = "overflow";
        do_reset();
        send(8'h90);
        send(8'h3C); push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C40, 16'h0, 16'h0, 16'h0)); send(8'h40);
        send(8'h3D); push(1'b1, 1'b0, 5'b00110, tbl(16'h0, 16'h3C40, 16'h3D40, 16'h0, 16'h0)); send(8'h40);
        send(8'h3E); push(1'b1, 1'b0, 5'b01110, tbl(16'h0, 16'h3C40, 16'h3D40, 16'h3E40, 16'h0)); send(8'h40);
        full = tbl(16'h0, 16'h3C40, 16'h3D40, 16'h3E40, 16'h3F40);
        send(8'h3F); push(1'b1, 1'b0, 5'b11110, full); send(8'h40);
        send(8'h90); send(8'h64); push(1'b0, 1'b1, 5'b11110, full); send(8'h7F);
        send(8'h80); send(8'h3C);
        push(1'b1, 1'b0, 5'b11100, tbl(16'h0, 16'h0, 16'h3D40, 16'h3E40, 16'h3F40));
        send(8'h00);
        send(8'h90); send(8'h64);
        push(1'b1, 1'b0, 5'b11110, tbl(16'h0, 16'h647F, 16'h3D40, 16'h3E40, 16'h3F40));
        send(8'h7F);
        end_check();
    endtask

    task automatic test_retrigger();
        tname = "retrigger";
        do_reset();
        send(8'h90); send(8'h3C);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C10, 16'h0, 16'h0, 16'h0));
        send(8'h10);
        send(8'h90); send(8'h3C);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C70, 16'h0, 16'h0, 16'h0));
        send(8'h70);
        send(8'h80); send(8'h3D); send(8'h00);
        send(8'hB0); send(8'h07); send(8'h64);
        send(8'h90); send(8'hF8); send(8'h3E);
        push(1'b1, 1'b0, 5'b00110, tbl(16'h0, 16'h3C70, 16'h3E20, 16'h0, 16'h0));
        send(8'h20);
        end_check();
    endtask

    task automatic test_filter();
        tname = "filter";
        do_reset();
        chan_pulses = 0;
        send(8'h91); send(8'h3C);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C64, 16'h0, 16'h0, 16'h0));
        send(8'h64);
        send(8'hA0); send(8'h3C); send(8'h10);
        send(8'h3C); send(8'h10);
        send(8'h90); send(8'h3C);
        send(8'h80); send(8'h3C);
        push(1'b1, 1'b0, 5'b00000, 80'd0);
        send(8'h00);
        end_check();
        n_checks++;
        if (chan_pulses != 0 || c_on !== 5'b00000) begin
            n_fail++;
            $display("FAIL filter_rejected: got pulses=%0d mask=%b, required pulses=0 mask=00000", chan_pulses, c_on);
        end
        send(8'h90); send(8'h3C);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C64, 16'h0, 16'h0, 16'h0));
        send(8'h64);
        end_check();
        n_checks++;
        if (chan_pulses != 1 || c_on !== 5'b00010 || c_data[1] !== 16'h3C64) begin
            n_fail++;
            $display("FAIL filter_accepted: got pulses=%0d mask=%b slot1=%h, required pulses=1 mask=00010 slot1=3c64",
                     chan_pulses, c_on, c_data[1]);
        end
    endtask

    task automatic test_all_off_and_reset();
        tname = "all_notes_off";
        do_reset();
        send(8'h90);
        send(8'h3C); push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h3C10, 16'h0, 16'h0, 16'h0)); send(8'h10);
        send(8'h3D); push(1'b1, 1'b0, 5'b00110, tbl(16'h0, 16'h3C10, 16'h3D20, 16'h0, 16'h0)); send(8'h20);
        send(8'h3E); push(1'b1, 1'b0, 5'b01110, tbl(16'h0, 16'h3C10, 16'h3D20, 16'h3E30, 16'h0)); send(8'h30);
        send(8'hB0); send(8'h7B); push(1'b1, 1'b0, 5'b00000, 80'd0); send(8'h00);
        send(8'hB0); send(8'h7B); send(8'h00);
        end_check();

        tname = "async_reset";
        send(8'h90); send(8'h45);
        push(1'b1, 1'b0, 5'b00010, tbl(16'h0, 16'h4511, 16'h0, 16'h0, 16'h0));
        send(8'h11);
        send(8'h90); send(8'h46);
        tick(8'h00, 1'b0);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_chg, o_ovf, o_on, obs()} !== 87'd0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got chg=%0b ovf=%0b mask=%b data=%h, required all 0 before any edge",
                     o_chg, o_ovf, o_on, obs());
        end
        #1 rst = 1'b0;
        cur_mask = '0;
        cur_data = '0;
        send(8'h50); send(8'h60);
        end_check();
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_back_to_back();
        test_overflow();
        test_retrigger();
        test_filter();
        test_all_off_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
